// File: rtl/act_scheduler.sv
// act_scheduler: round-robin activate arbiter that enforces a minimum
// spacing between activates (TRRD) and a cap of ACT_LIMIT activates in any
// rolling TFAW-cycle window. All outputs are registered.
module act_scheduler #(
    parameter int NREQ      = 4,
    parameter int TFAW      = 10,
    parameter int TRRD      = 2,
    parameter int ACT_LIMIT = 4
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [NREQ-1:0]                ACTREQ,
    output logic [NREQ-1:0]                ACTGNT,
    output logic                           ACTVALID,
    output logic [$clog2(NREQ)-1:0]        ACTID,
    output logic [$clog2(ACT_LIMIT+1)-1:0] WINCNT,
    output logic                           THROTTLE
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(ACT_LIMIT + 1);

    // Bits of the issue history that fall inside the TRRD shadow
    // (the previous TRRD-1 cycles); empty when TRRD is 1.
    localparam logic [TFAW-1:0] TRRD_MASK = TFAW'((64'(1) << (TRRD - 1)) - 64'(1));

    // hist_reg[0] is the current cycle, hist_reg[k] is k cycles ago.
    logic [TFAW-1:0] hist_reg, hist_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic            valid_reg, valid_next;
    logic [IDW-1:0]  id_reg, id_next;
    logic [CW-1:0]   win_cnt_reg, win_cnt_next;
    logic            throttle_reg, throttle_next;
    logic [IDW-1:0]  ptr_reg, ptr_next;

    logic [NREQ-1:0] eligible;
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic            trrd_block;
    logic            faw_block;
    logic            issue;
    logic [CW-1:0]   prev_cnt;
    logic [CW:0]     win_sum;

    // Round-robin search over requesters, starting one above the last grant.
    always_comb begin
        logic [IDW-1:0] cand;
        eligible   = ACTREQ & ~gnt_reg;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(ptr_reg) + i) % NREQ);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Timing gates, issue decision and next values of all registered state.
    always_comb begin
        // Window count over the previous TFAW-1 cycles: drop the oldest entry.
        prev_cnt      = win_cnt_reg - CW'(hist_reg[TFAW-1]);
        trrd_block    = |(hist_reg & TRRD_MASK);
        faw_block     = (prev_cnt >= CW'(ACT_LIMIT));
        issue         = pick_found && !trrd_block && !faw_block;
        // THROTTLE only reflects tFAW once the TRRD shadow has passed.
        throttle_next = pick_found && !trrd_block && faw_block;
        valid_next    = issue;
        id_next       = issue ? pick_idx : '0;
        gnt_next      = issue ? (NREQ'(1) << pick_idx) : '0;
        ptr_next      = issue ? pick_idx : ptr_reg;
        hist_next     = {hist_reg[TFAW-2:0], issue};
        win_sum       = {1'b0, prev_cnt} + (CW+1)'(issue);
        win_cnt_next  = (win_sum > (CW+1)'(ACT_LIMIT)) ? CW'(ACT_LIMIT) : win_sum[CW-1:0];
    end

    // State registers; reset discards history and gives requester 0 first pick.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hist_reg     <= '0;
            gnt_reg      <= '0;
            valid_reg    <= 1'b0;
            id_reg       <= '0;
            win_cnt_reg  <= '0;
            throttle_reg <= 1'b0;
            ptr_reg      <= IDW'(NREQ - 1);
        end else begin
            hist_reg     <= hist_next;
            gnt_reg      <= gnt_next;
            valid_reg    <= valid_next;
            id_reg       <= id_next;
            win_cnt_reg  <= win_cnt_next;
            throttle_reg <= throttle_next;
            ptr_reg      <= ptr_next;
        end
    end

    assign ACTGNT   = gnt_reg;
    assign ACTVALID = valid_reg;
    assign ACTID    = id_reg;
    assign WINCNT   = win_cnt_reg;
    assign THROTTLE = throttle_reg;

endmodule

// File: tb/tb_act_scheduler.sv
// Directed and random checks of act_scheduler at default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_act_scheduler;

    localparam int NREQ      = 4;
    localparam int TFAW      = 10;
    localparam int TRRD      = 2;
    localparam int ACT_LIMIT = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req   = '0;
    logic [NREQ-1:0] gnt;
    logic            valid;
    logic [1:0]      id;
    logic [2:0]      win;
    logic            thr;

    int n_checks = 0;
    int n_errors = 0;

    act_scheduler #(.NREQ(NREQ), .TFAW(TFAW), .TRRD(TRRD), .ACT_LIMIT(ACT_LIMIT)) dut (
        .Clock   (clk),
        .Reset   (rst_n),
        .ACTREQ  (req),
        .ACTGNT  (gnt),
        .ACTVALID(valid),
        .ACTID   (id),
        .WINCNT  (win),
        .THROTTLE(thr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_id"}, 32'(id), 0);
        check({tag, "_win"}, 32'(win), 0);
        check({tag, "_thr"}, 32'(thr), 0);
    endtask

    // Holds reset for two cycles, releases it, then idles one cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        check_zero("rst_hold");
        rst_n = 1'b1;
        tick();
    endtask

    // Scenario tables (cycle offsets from the first issue cycle c).
    int s1_win[21] = '{1,1,2,2,3,3,4,4,4,4,4,4,4,4,4,4,4,4,4,4,4};
    logic [20:0] s1_issue;
    logic [20:0] s1_thr;
    int s2_id[11] = '{0,0,1,0,2,0,3,0,0,0,0};
    logic [10:0] s2_issue;

    // Random-phase scoreboard state.
    logic [NREQ-1:0] req_applied, prev_gnt, elig, exp_gnt;
    logic [15:0]     hist_b;
    int              ptr_m, exp_id, win_prev, cand;
    logic            trrd_ok, exp_valid, exp_thr, found;
    int              wait_cnt[NREQ];

    initial begin
        s1_issue = '0;
        foreach (s1_issue[k]) if (k inside {0,2,4,6,10,12,14,16,20}) s1_issue[k] = 1'b1;
        s1_thr = '0;
        foreach (s1_thr[k]) if (k inside {8,9,18,19}) s1_thr[k] = 1'b1;
        s2_issue = '0;
        foreach (s2_issue[k]) if (k inside {0,2,4,6,10}) s2_issue[k] = 1'b1;

        // Single requester held high: tFAW throttling pattern.
        do_reset();
        req = 4'b0001;
        for (int k = 0; k <= 20; k++) begin
            tick();
            check($sformatf("s1_valid_c%0d", k), 32'(valid), 32'(s1_issue[k]));
            check($sformatf("s1_thr_c%0d", k), 32'(thr), 32'(s1_thr[k]));
            check($sformatf("s1_win_c%0d", k), 32'(win), 32'(s1_win[k]));
            check($sformatf("s1_gnt_c%0d", k), 32'(gnt), s1_issue[k] ? 32'h1 : 32'h0);
            if (valid) $display("s1 cycle c+%0d: grant id=%0d wincnt=%0d", k, id, win);
        end

        // All four requesting: round-robin order.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k <= 10; k++) begin
            tick();
            check($sformatf("s2_valid_c%0d", k), 32'(valid), 32'(s2_issue[k]));
            check($sformatf("s2_id_c%0d", k), 32'(id), 32'(s2_id[k]));
            if (valid) $display("s2 cycle c+%0d: grant id=%0d", k, id);
        end

        // Grant to 1, then 1010 applied: 3 wins first, 1 two cycles later.
        do_reset();
        req = 4'b0010;
        tick();
        check("s3_gnt1", 32'(gnt), 32'h2);
        req = 4'b1010;
        tick();
        check("s3_trrd_gap", 32'(valid), 0);
        tick();
        check("s3_gnt3", 32'(gnt), 32'h8);
        check("s3_id3", 32'(id), 3);
        req = 4'b0010;
        tick();
        check("s3_gap2", 32'(valid), 0);
        tick();
        check("s3_gnt1b", 32'(gnt), 32'h2);
        check("s3_id1b", 32'(id), 1);
        $display("s3: grants 1 -> 3 -> 1 observed");
        req = 4'b0000;

        // Reset mid-burst: async clear, then history discarded.
        do_reset();
        req = 4'b0100;
        for (int k = 0; k <= 4; k++) begin
            tick();
            check($sformatf("s4_pre_valid_c%0d", k), 32'(valid), (k % 2 == 0) ? 1 : 0);
        end
        rst_n = 1'b0;
        #1;
        check_zero("s4_async");
        tick();
        check_zero("s4_inreset");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            check($sformatf("s4_valid_r%0d", k), 32'(valid), (k % 2 == 0 && k <= 6) ? 1 : 0);
            check($sformatf("s4_thr_r%0d", k), 32'(thr), (k == 8) ? 1 : 0);
            if (k == 0) check("s4_id_r0", 32'(id), 2);
            if (k == 6) check("s4_win_r6", 32'(win), 4);
        end
        $display("s4: post-reset burst of 4 observed");

        // Withdrawal during tFAW block: no grant, pointer unchanged.
        do_reset();
        req = 4'b0001;
        for (int k = 0; k <= 6; k++) tick();
        check("s5_win_c6", 32'(win), 4);
        req = 4'b0000;
        tick();
        check("s5_thr_c7", 32'(thr), 0);
        req = 4'b0010;
        tick();
        check("s5_thr_c8", 32'(thr), 1);
        check("s5_valid_c8", 32'(valid), 0);
        req = 4'b0000;
        tick();
        check("s5_thr_c9", 32'(thr), 0);
        check("s5_gnt_c9", 32'(gnt), 0);
        tick();
        check("s5_gnt_c10", 32'(gnt), 0);
        req = 4'b1010;
        tick();
        check("s5_gnt_c11", 32'(gnt), 32'h2);
        check("s5_id_c11", 32'(id), 1);
        $display("s5: withdrawn request skipped, pointer held");
        req = 4'b0000;

        // Random traffic against a scoreboard built from the rules.
        do_reset();
        req_applied = '0;
        prev_gnt    = '0;
        hist_b      = '0;
        ptr_m       = NREQ - 1;
        foreach (wait_cnt[k]) wait_cnt[k] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            tick();
            elig    = req_applied & ~prev_gnt;
            trrd_ok = 1'b1;
            for (int j = 0; j <= TRRD - 2; j++) if (hist_b[j]) trrd_ok = 1'b0;
            win_prev = 0;
            for (int j = 0; j <= TFAW - 2; j++) win_prev += int'(hist_b[j]);
            exp_valid = (elig != 0) && trrd_ok && (win_prev < ACT_LIMIT);
            exp_thr   = (elig != 0) && trrd_ok && (win_prev >= ACT_LIMIT);
            found  = 1'b0;
            exp_id = 0;
            for (int i = 1; i <= NREQ; i++) begin
                cand = (ptr_m + i) % NREQ;
                if (!found && elig[cand]) begin
                    found  = 1'b1;
                    exp_id = cand;
                end
            end
            exp_gnt = exp_valid ? NREQ'(1 << exp_id) : '0;
            check("rnd_valid", 32'(valid), 32'(exp_valid));
            check("rnd_thr", 32'(thr), 32'(exp_thr));
            check("rnd_gnt", 32'(gnt), 32'(exp_gnt));
            check("rnd_id", 32'(id), exp_valid ? exp_id : 0);
            check("rnd_win", 32'(win), 32'(win_prev + int'(exp_valid)));
            for (int k = 0; k < NREQ; k++) begin
                if (req_applied[k] && valid) wait_cnt[k]++;
                if (gnt[k]) begin
                    check("rnd_wait_bound", 32'(wait_cnt[k] <= NREQ), 1);
                    wait_cnt[k] = 0;
                end
            end
            hist_b   = {hist_b[14:0], exp_valid};
            if (exp_valid) ptr_m = exp_id;
            prev_gnt = exp_gnt;
            // Requesters drop on grant and re-raise at random.
            req = req & ~gnt;
            for (int k = 0; k < NREQ; k++)
                if (!req[k] && $urandom_range(0, 2) == 0) req[k] = 1'b1;
            req_applied = req;
        end
        $display("random phase: 10000 cycles scored");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/act_scheduler.md
ACT_SCHEDULER -- requirements
Module: act_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of activate requesters; legal range 2..16.
REQ-002 Parameter TFAW, default 10: rolling four-activate window length in cycles; legal range ACT_LIMIT..64.
REQ-003 Parameter TRRD, default 2: minimum cycles between consecutive activates; legal range 1..TFAW.
REQ-004 Parameter ACT_LIMIT, default 4: maximum activates in any TFAW-cycle window.
REQ-005 Clock  input  1  clock; all state SHALL update on the rising edge only.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 ACTREQ  input  NREQ  per-requester activate request, level, held until granted.
REQ-008 ACTGNT  output  NREQ  one-hot grant, registered, high for exactly one cycle per issued activate.
REQ-009 ACTVALID  output  1  registered, high in every cycle in which an activate issues (the "issue cycle").
REQ-010 ACTID  output  clog2(NREQ)  index of the granted requester, valid only while ACTVALID=1, otherwise 0.
REQ-011 WINCNT  output  clog2(ACT_LIMIT+1)  number of issue cycles within the current cycle and the previous TFAW-1 cycles.
REQ-012 THROTTLE  output  1  registered, high in a cycle with an eligible request pending but blocked only by the tFAW rule.

Function
REQ-013 Cycle n SHALL be an issue cycle only if: (a) an eligible request exists, (b) no issue occurred in cycles n-TRRD+1..n-1, and (c) fewer than ACT_LIMIT issues occurred in cycles n-TFAW+1..n-1.
REQ-014 Eligible requests for cycle n SHALL be the bits of ACTREQ sampled at the edge that starts cycle n, excluding the requester granted in cycle n-1.
REQ-015 Arbitration SHALL be round-robin: search starts at the index one above the last granted index, wrapping modulo NREQ.
REQ-016 The round-robin pointer SHALL advance only in issue cycles.
REQ-017 ACTGNT, ACTVALID, and ACTID SHALL change together; the latency from ACTREQ rise to grant is 1 cycle when unblocked.
REQ-018 The tFAW history SHALL be a TFAW-deep record of past issue cycles; any TFAW consecutive cycles SHALL never contain more than ACT_LIMIT issue cycles.
REQ-019 WINCNT SHALL saturate arithmetically at ACT_LIMIT, never wrap, and decrement as entries age out of the window.
REQ-020 If ACTREQ[k] drops before it is granted, no grant SHALL be issued to k; a withdrawal SHALL not move the pointer.
REQ-021 If both TRRD and tFAW block a request, THROTTLE SHALL be high only if tFAW is still blocking after TRRD has expired.
REQ-022 No grant SHALL ever be issued to a requester whose sampled ACTREQ bit is 0.

Reset
REQ-023 While Reset=0, the outputs SHALL be ACTGNT=0, ACTVALID=0, ACTID=0, WINCNT=0, THROTTLE=0, regardless of Clock.
REQ-024 Reset SHALL clear the tFAW history and the TRRD timer, and SHALL set the round-robin pointer to NREQ-1, so that requester 0 has the highest priority first.
REQ-025 Reset asserted mid-burst SHALL discard all history; the first request after Reset=1 SHALL issue without tFAW or TRRD delay.

Verification (defaults NREQ=4, TFAW=10, TRRD=2, ACT_LIMIT=4; c = first issue cycle)
REQ-026 ACTREQ[0] held high -> issue cycles c, c+2, c+4, c+6, c+10, c+12, c+14, c+16, c+20; THROTTLE=1 in c+8 and c+9; WINCNT=4 at c+6.
REQ-027 ACTREQ=4'b1111 held -> ACTID sequence 0,1,2,3,0 at cycles c, c+2, c+4, c+6, c+10.
REQ-028 After a grant to requester 1, ACTREQ=4'b1010 applied simultaneously -> grant to 3 first, then to 1 two cycles later.
REQ-029 Reset pulsed low after 3 issues in 5 cycles -> all outputs 0 during reset; after release, ACTREQ[2] is granted the next cycle, and 4 issues are allowed at 2-cycle spacing.
REQ-030 ACTREQ[1] raised in a tFAW-blocked cycle and dropped before the window frees -> no ACTGNT[1], pointer unchanged, THROTTLE falls when the request drops.
REQ-031 Random ACTREQ for 10000 cycles -> a scoreboard confirms REQ-013, REQ-018, and REQ-022 every cycle, and that no requester waits longer than NREQ issue slots.
